// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four selectable test patterns (solid, bars, checker, gradient).
// Every video output is registered from the same counter state, so all outputs stay aligned.
module vga_pattern_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_POL  = 0,
  parameter int SQ_LOG2   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  sw,
  input  logic [1:0]  mode,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start
);

  // Legal configurations keep H_TOTAL and V_TOTAL within the 10-bit counters and SQ_LOG2 <= 9.
  localparam int H_TOTAL      = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_DISPLAY + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_DISPLAY + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int BAR_W        = H_DISPLAY / 8;
  localparam int DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic SYNC_ON    = (SYNC_POL != 0);

  localparam logic [1:0] MODE_SOLID    = 2'd0;
  localparam logic [1:0] MODE_BARS     = 2'd1;
  localparam logic [1:0] MODE_CHECKER  = 2'd2;
  localparam logic [1:0] MODE_GRADIENT = 2'd3;

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [7:0]       frame_cnt;
  logic [1:0]       active_mode;
  logic [2:0]       active_col;

  logic tick;
  logic h_wrap;
  logic v_wrap;
  logic frame_wrap;

  assign tick       = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_wrap     = (h_cnt == 10'(H_TOTAL - 1));
  assign v_wrap     = (v_cnt == 10'(V_TOTAL - 1));
  assign frame_wrap = tick && h_wrap && v_wrap;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
      end
    end
  end

  // Pattern selection is frozen for a whole frame; it only changes on the wrap to (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_mode <= MODE_SOLID;
      active_col  <= 3'b000;
      frame_cnt   <= 8'd0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      if (frame_wrap) begin
        active_mode <= mode;
        active_col  <= sw;
        frame_cnt   <= frame_cnt + 8'd1;
      end
    end
  end

  function automatic logic [11:0] solid_colour(input logic [2:0] c);
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction

  logic       in_h_sync;
  logic       in_v_sync;
  logic       visible;
  logic [2:0] bar_idx;
  logic       checker_odd;
  logic [11:0] pattern;

  assign in_h_sync   = (h_cnt >= 10'(H_SYNC_START)) && (h_cnt < 10'(H_SYNC_END));
  assign in_v_sync   = (v_cnt >= 10'(V_SYNC_START)) && (v_cnt < 10'(V_SYNC_END));
  assign visible     = (h_cnt < 10'(H_DISPLAY)) && (v_cnt < 10'(V_DISPLAY));
  assign checker_odd = h_cnt[SQ_LOG2] ^ v_cnt[SQ_LOG2];

  // Bar index is the number of bar boundaries already passed; anything past the last boundary is bar 7.
  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt >= 10'(i * BAR_W)) bar_idx = 3'(i);
    end
  end

  always_comb begin
    pattern = 12'h000;
    case (active_mode)
      MODE_SOLID:    pattern = solid_colour(active_col);
      MODE_BARS:     pattern = solid_colour(bar_idx);
      MODE_CHECKER:  pattern = checker_odd ? 12'h000 : solid_colour(active_col);
      MODE_GRADIENT: pattern = {h_cnt[9:6], v_cnt[8:5], frame_cnt[3:0]};
      default:       pattern = 12'h000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync    <= ~SYNC_ON;
      vsync    <= ~SYNC_ON;
      video_on <= 1'b0;
      rgb      <= 12'h000;
      pixel_x  <= 10'd0;
      pixel_y  <= 10'd0;
    end else begin
      hsync    <= in_h_sync ? SYNC_ON : ~SYNC_ON;
      vsync    <= in_v_sync ? SYNC_ON : ~SYNC_ON;
      video_on <= visible;
      rgb      <= visible ? pattern : 12'h000;
      pixel_x  <= h_cnt;
      pixel_y  <= v_cnt;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: two small configurations checked every cycle against a
// tick-counting frame model, plus directed pixel, sync-width and reset checks.
module tb_vga_pattern_gen;

  localparam int A_D = 2, A_HD = 64, A_HF = 4, A_HS = 8, A_HB = 4;
  localparam int A_VD = 24, A_VF = 2, A_VS = 2, A_VB = 2, A_POL = 0, A_SQ = 3;
  localparam int B_D = 1, B_HD = 8, B_HF = 2, B_HS = 2, B_HB = 2;
  localparam int B_VD = 4, B_VF = 1, B_VS = 1, B_VB = 1, B_POL = 1, B_SQ = 1;
  localparam int BUDGET = 12000;

  typedef struct {
    int d, hd, hf, hs, hb, vd, vf, vs, vb, pol, sq;
  } cfg_t;

  typedef struct {
    logic        hs, vs, von, fs;
    logic [11:0] rgb;
    logic [9:0]  px, py;
  } vout_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] mode_a = 2'd0, mode_b = 2'd3;
  logic [2:0] sw_a = 3'b101, sw_b = 3'b011;

  logic hsync_a, vsync_a, video_on_a, frame_start_a;
  logic hsync_b, vsync_b, video_on_b, frame_start_b;
  logic [11:0] rgb_a, rgb_b;
  logic [9:0] pixel_x_a, pixel_y_a, pixel_x_b, pixel_y_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .CLK_DIV(A_D), .H_DISPLAY(A_HD), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_DISPLAY(A_VD), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .SYNC_POL(A_POL), .SQ_LOG2(A_SQ)
  ) dut_a (
    .clk(clk), .reset(reset), .sw(sw_a), .mode(mode_a),
    .hsync(hsync_a), .vsync(vsync_a), .rgb(rgb_a), .video_on(video_on_a),
    .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .frame_start(frame_start_a)
  );

  vga_pattern_gen #(
    .CLK_DIV(B_D), .H_DISPLAY(B_HD), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_DISPLAY(B_VD), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .SYNC_POL(B_POL), .SQ_LOG2(B_SQ)
  ) dut_b (
    .clk(clk), .reset(reset), .sw(sw_b), .mode(mode_b),
    .hsync(hsync_b), .vsync(vsync_b), .rgb(rgb_b), .video_on(video_on_b),
    .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .frame_start(frame_start_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t: timed out waiting", name, $time);
  endtask

  function automatic cfg_t cfg_of(input int i);
    cfg_t c;
    if (i == 0) c = '{d:A_D, hd:A_HD, hf:A_HF, hs:A_HS, hb:A_HB, vd:A_VD, vf:A_VF, vs:A_VS, vb:A_VB, pol:A_POL, sq:A_SQ};
    else        c = '{d:B_D, hd:B_HD, hf:B_HF, hs:B_HS, hb:B_HB, vd:B_VD, vf:B_VF, vs:B_VS, vb:B_VB, pol:B_POL, sq:B_SQ};
    return c;
  endfunction

  function automatic logic [11:0] colour(input int bits);
    return ((bits & 4) != 0 ? 12'hF00 : 12'h000) |
           ((bits & 2) != 0 ? 12'h0F0 : 12'h000) |
           ((bits & 1) != 0 ? 12'h00F : 12'h000);
  endfunction

  function automatic vout_t reset_out(input cfg_t c);
    vout_t o;
    o.hs = (c.pol == 0); o.vs = (c.pol == 0);
    o.von = 1'b0; o.fs = 1'b0; o.rgb = 12'h000; o.px = 10'd0; o.py = 10'd0;
    return o;
  endfunction

  // Expected outputs for the pixel at linear frame position p.
  function automatic vout_t model_out(input cfg_t c, input longint p, input int md, input int col, input int fc);
    vout_t o;
    int ht = c.hd + c.hf + c.hs + c.hb;
    int h = int'(p % ht);
    int v = int'(p / ht);
    int k;
    int px_rgb;
    logic in_hs = (h >= c.hd + c.hf) && (h < c.hd + c.hf + c.hs);
    logic in_vs = (v >= c.vd + c.vf) && (v < c.vd + c.vf + c.vs);
    o.hs = in_hs ? (c.pol != 0) : (c.pol == 0);
    o.vs = in_vs ? (c.pol != 0) : (c.pol == 0);
    o.von = (h < c.hd) && (v < c.vd);
    k = h / (c.hd / 8);
    if (k > 7) k = 7;
    case (md)
      0: px_rgb = int'(colour(col));
      1: px_rgb = int'(colour(k));
      2: px_rgb = ((((h >> c.sq) ^ (v >> c.sq)) & 1) == 0) ? int'(colour(col)) : 0;
      default: px_rgb = (((h / 64) % 16) << 8) | (((v / 32) % 16) << 4) | (fc % 16);
    endcase
    o.rgb = o.von ? 12'(px_rgb) : 12'h000;
    o.px = 10'(h); o.py = 10'(v); o.fs = 1'b0;
    return o;
  endfunction

  function automatic vout_t act_of(input int i);
    vout_t o;
    if (i == 0) begin
      o.hs = hsync_a; o.vs = vsync_a; o.von = video_on_a; o.fs = frame_start_a;
      o.rgb = rgb_a; o.px = pixel_x_a; o.py = pixel_y_a;
    end else begin
      o.hs = hsync_b; o.vs = vsync_b; o.von = video_on_b; o.fs = frame_start_b;
      o.rgb = rgb_b; o.px = pixel_x_b; o.py = pixel_y_b;
    end
    return o;
  endfunction

  // Model: count clocks and pixel ticks since reset; latch inputs whenever a whole frame of ticks completes.
  task automatic model_and_compare();
    longint m_edges[2];
    longint m_ticks[2];
    int m_mode[2], m_col[2], m_fcnt[2];
    vout_t m_exp[2];
    vout_t exp_o, act_o;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        cfg_t c = cfg_of(i);
        longint ft = longint'(c.hd + c.hf + c.hs + c.hb) * longint'(c.vd + c.vf + c.vs + c.vb);
        if (reset) begin
          m_edges[i] = 0; m_ticks[i] = 0; m_mode[i] = 0; m_col[i] = 0; m_fcnt[i] = 0;
          m_exp[i] = reset_out(c);
        end else begin
          logic tick = (m_edges[i] % c.d) == longint'(c.d - 1);
          m_exp[i] = model_out(c, m_ticks[i] % ft, m_mode[i], m_col[i], m_fcnt[i]);
          m_exp[i].fs = tick && (((m_ticks[i] + 1) % ft) == 0);
          if (tick) begin
            m_ticks[i]++;
            if (m_ticks[i] % ft == 0) begin
              m_mode[i] = (i == 0) ? int'(mode_a) : int'(mode_b);
              m_col[i]  = (i == 0) ? int'(sw_a) : int'(sw_b);
              m_fcnt[i] = (m_fcnt[i] + 1) % 256;
            end
          end
          m_edges[i]++;
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        exp_o = reset ? reset_out(cfg_of(i)) : m_exp[i];
        act_o = act_of(i);
        check(i == 0 ? "a.hsync" : "b.hsync", 32'(act_o.hs), 32'(exp_o.hs));
        check(i == 0 ? "a.vsync" : "b.vsync", 32'(act_o.vs), 32'(exp_o.vs));
        check(i == 0 ? "a.video_on" : "b.video_on", 32'(act_o.von), 32'(exp_o.von));
        check(i == 0 ? "a.frame_start" : "b.frame_start", 32'(act_o.fs), 32'(exp_o.fs));
        check(i == 0 ? "a.rgb" : "b.rgb", 32'(act_o.rgb), 32'(exp_o.rgb));
        check(i == 0 ? "a.pixel_x" : "b.pixel_x", 32'(act_o.px), 32'(exp_o.px));
        check(i == 0 ? "a.pixel_y" : "b.pixel_y", 32'(act_o.py), 32'(exp_o.py));
      end
    end
  endtask

  task automatic wait_pixel(input int x, input int y, input string name, input logic [11:0] exp);
    int b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!(pixel_x_a == 10'(x) && pixel_y_a == 10'(y)) && b < BUDGET);
    if (b >= BUDGET) timeout(name);
    else check(name, 32'(rgb_a), 32'(exp));
  endtask

  task automatic wait_fs_a();
    int b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (frame_start_a !== 1'b1 && b < BUDGET);
    if (b >= BUDGET) timeout("a.frame_start wait");
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return hsync_a;
      1:       return vsync_a;
      default: return frame_start_b;
    endcase
  endfunction

  // Width and period, in clocks, of the asserted level of a periodic signal.
  task automatic measure(input int which, input logic act, input int exp_w, input int exp_p, input string name);
    int b = 0, w = 0, p = 0;
    while (sig(which) == act && b < BUDGET) begin @(negedge clk); b++; end
    while (sig(which) != act && b < BUDGET) begin @(negedge clk); b++; end
    while (sig(which) == act && b < BUDGET) begin w++; p++; @(negedge clk); b++; end
    while (sig(which) != act && b < BUDGET) begin p++; @(negedge clk); b++; end
    if (b >= BUDGET) timeout(name);
    else begin
      check({name, " width"}, 32'(w), 32'(exp_w));
      check({name, " period"}, 32'(p), 32'(exp_p));
    end
  endtask

  initial begin
    int cnt;
    fork
      model_and_compare();
    join_none

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("reset a.hsync", 32'(hsync_a), 32'd1);
    check("reset a.vsync", 32'(vsync_a), 32'd1);
    check("reset b.hsync", 32'(hsync_b), 32'd0);
    check("reset a.rgb", 32'(rgb_a), 32'h000);
    check("reset a.video_on", 32'(video_on_a), 32'd0);
    check("reset a.pixel_x", 32'(pixel_x_a), 32'd0);
    check("reset a.frame_start", 32'(frame_start_a), 32'd0);
    reset = 1'b0;

    // Frame 1 runs with the reset selection (solid black); sw=101 latches at its end.
    wait_pixel(5, 3, "frame1 black", 12'h000);
    wait_fs_a();
    wait_pixel(5, 3, "solid 101", 12'hF0F);
    wait_pixel(70, 3, "solid blanking", 12'h000);
    check("blanking video_on", 32'(video_on_a), 32'd0);
    mode_a = 2'd1;
    wait_pixel(5, 10, "solid holds mid-frame", 12'hF0F);

    wait_fs_a();
    wait_pixel(0, 2, "bar0", 12'h000);
    wait_pixel(8, 2, "bar1", 12'h00F);
    wait_pixel(20, 2, "bar2", 12'h0F0);
    wait_pixel(63, 2, "bar7", 12'hFFF);
    measure(0, 1'b0, A_HS * A_D, 80 * A_D, "hsync");
    mode_a = 2'd0;
    sw_a = 3'b110;

    wait_fs_a();
    wait_pixel(0, 10, "solid 110", 12'hFF0);
    mode_a = 2'd2;
    wait_pixel(8, 20, "mode change deferred", 12'hFF0);

    wait_fs_a();
    wait_pixel(7, 0, "checker (7,0)", 12'hFF0);
    wait_pixel(8, 0, "checker (8,0)", 12'h000);
    wait_pixel(8, 8, "checker (8,8)", 12'hFF0);
    mode_a = 2'd3;

    wait_fs_a();
    wait_pixel(5, 3, "gradient frame 5", 12'h005);
    measure(1, 1'b0, A_VS * 80 * A_D, 80 * 30 * A_D, "vsync");
    measure(2, 1'b1, 1, 98, "b.frame_start");

    // Asynchronous reset in the middle of a clock period.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async a.hsync", 32'(hsync_a), 32'd1);
    check("async a.rgb", 32'(rgb_a), 32'h000);
    check("async a.video_on", 32'(video_on_a), 32'd0);
    check("async a.pixel_x", 32'(pixel_x_a), 32'd0);
    check("async b.pixel_y", 32'(pixel_y_b), 32'd0);
    check("async b.hsync", 32'(hsync_b), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    do begin
      @(posedge clk);
      #1 cnt++;
    end while (frame_start_a !== 1'b1 && cnt < BUDGET);
    check("first frame_start after reset", 32'(cnt), 32'(80 * 30 * A_D));
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
